eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_tx_framer.sv | 163 ++++++++++++++++
 tb/tb_eth_tx_framer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the Ethernet TX framer.
//   - tx_state_t      : framer FSM state encoding
//   - HDR_LEN         : Ethernet header length in bytes (dst + src + EtherType)
//   - DEF_MIN_PAYLOAD : default minimum payload (shorter frames are zero padded)
//   - DEF_MAX_PAYLOAD : default maximum payload forwarded
//   - hdr_byte()      : selects header byte idx (0 = dst_mac[47:40])
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PAD     = 3'd3,
    ST_DRAIN   = 3'd4
  } tx_state_t;

  localparam int HDR_LEN         = 14;
  localparam int DEF_MIN_PAYLOAD = 46;
  localparam int DEF_MAX_PAYLOAD = 1500;

  // Header is {dst, src, ethertype} sent MSB first, so byte idx is found by
  // shifting the concatenation left by idx bytes and taking the top byte.
  function automatic logic [7:0] hdr_byte(input logic [47:0] dst,
                                          input logic [47:0] src,
                                          input logic [15:0] etype,
                                          input logic [3:0]  idx);
    logic [111:0] hdr_v;
    hdr_v    = {dst, src, etype} << {idx, 3'b000};
    hdr_byte = hdr_v[111:104];
  endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: wraps a payload byte stream into an Ethernet frame.
// Emits a 14-byte header (dst MAC, P_MAC_ADDR, EtherType), passes the payload
// through, zero pads short payloads to P_MIN_PAYLOAD and truncates payloads
// longer than P_MAX_PAYLOAD (the remainder is drained and err_oversize pulses).
// Ports:
//   sys_tx_clk, sys_tx_rst            : clock, async active-high reset
//   dst_mac, ethertype                : header fields, sampled at frame start
//   pl_byte/pl_byte_vld/pl_byte_rdy   : payload input stream (valid/ready)
//   pl_sof/pl_eof                     : payload first/last byte markers
//   tx_byte/tx_byte_vld/tx_byte_rdy   : framed output stream (valid/ready)
//   tx_sof/tx_eof                     : framed first/last byte markers
//   err_oversize                      : one-cycle pulse on payload truncation
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter logic [47:0] P_MAC_ADDR    = 48'h3A52023E1800,
  parameter int          P_MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter int          P_MAX_PAYLOAD = DEF_MAX_PAYLOAD
) (
  input  logic        sys_tx_clk,
  input  logic        sys_tx_rst,
  input  logic [47:0] dst_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  pl_byte,
  input  logic        pl_byte_vld,
  output logic        pl_byte_rdy,
  input  logic        pl_sof,
  input  logic        pl_eof,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_vld,
  input  logic        tx_byte_rdy,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        err_oversize
);

  localparam logic [10:0] MIN_CNT  = 11'(P_MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT  = 11'(P_MAX_PAYLOAD);
  localparam logic [3:0]  HDR_LAST = 4'(HDR_LEN - 1);

  tx_state_t   state_r, state_s;
  logic [3:0]  hdr_idx_r, hdr_idx_s;
  logic [10:0] cnt_r, cnt_s;        // payload bytes (data + pad) emitted so far
  logic [10:0] cnt_inc_s;
  logic [47:0] dst_r, dst_s;
  logic [15:0] etype_r, etype_s;
  logic        err_r, err_s;

  assign cnt_inc_s    = cnt_r + 11'd1;
  assign err_oversize = err_r;

  // State and datapath registers.
  always_ff @(posedge sys_tx_clk or posedge sys_tx_rst) begin
    if (sys_tx_rst) begin
      state_r   <= ST_IDLE;
      hdr_idx_r <= 4'd0;
      cnt_r     <= 11'd0;
      dst_r     <= 48'd0;
      etype_r   <= 16'd0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      hdr_idx_r <= hdr_idx_s;
      cnt_r     <= cnt_s;
      dst_r     <= dst_s;
      etype_r   <= etype_s;
      err_r     <= err_s;
    end
  end

  // Next-state, counter updates and stream outputs.
  always_comb begin
    state_s     = state_r;
    hdr_idx_s   = hdr_idx_r;
    cnt_s       = cnt_r;
    dst_s       = dst_r;
    etype_s     = etype_r;
    err_s       = 1'b0;
    tx_byte     = 8'h00;
    tx_byte_vld = 1'b0;
    tx_sof      = 1'b0;
    tx_eof      = 1'b0;
    pl_byte_rdy = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Stray bytes without SOF are swallowed; the SOF byte is held off
        // so it can be forwarded after the header.
        pl_byte_rdy = !pl_sof;
        if (pl_byte_vld && pl_sof) begin
          dst_s     = dst_mac;
          etype_s   = ethertype;
          cnt_s     = 11'd0;
          hdr_idx_s = 4'd0;
          state_s   = ST_HDR;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_HDR: begin
        tx_byte     = hdr_byte(dst_r, P_MAC_ADDR, etype_r, hdr_idx_r);
        tx_byte_vld = 1'b1;
        tx_sof      = (hdr_idx_r == 4'd0);
        if (tx_byte_rdy) begin
          if (hdr_idx_r == HDR_LAST) begin
            state_s = ST_PAYLOAD;
          end else begin
            hdr_idx_s = hdr_idx_r + 4'd1;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        tx_byte     = pl_byte;
        tx_byte_vld = pl_byte_vld;
        pl_byte_rdy = tx_byte_rdy;
        // Frame ends here either on a real EOF with enough payload or on the
        // truncation point; markers depend only on held inputs so they stay
        // stable while stalled.
        tx_eof      = (cnt_inc_s == MAX_CNT) || (pl_eof && (cnt_inc_s >= MIN_CNT));
        if (pl_byte_vld && tx_byte_rdy) begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s == MAX_CNT) begin
            if (pl_eof) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_DRAIN;
              err_s   = 1'b1;
            end
          end else if (pl_eof) begin
            state_s = (cnt_inc_s >= MIN_CNT) ? ST_IDLE : ST_PAD;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_PAD: begin
        tx_byte_vld = 1'b1;
        tx_eof      = (cnt_inc_s >= MIN_CNT);
        if (tx_byte_rdy) begin
          cnt_s   = cnt_inc_s;
          state_s = (cnt_inc_s >= MIN_CNT) ? ST_IDLE : ST_PAD;
        end else begin
          state_s = ST_PAD;
        end
      end
      ST_DRAIN: begin
        pl_byte_rdy = 1'b1;
        if (pl_byte_vld && pl_eof) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: randomized self-checking bench for eth_tx_framer.
// The reference model builds the expected framed byte list directly from the
// frame rules (header, forwarded payload, zero pad, eof on last byte).
module tb_eth_tx_framer;

  localparam logic [47:0] MAC = 48'h3A52023E1800;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dst_mac;
  logic [15:0] ethertype;
  logic [7:0]  pl_byte;
  logic        pl_byte_vld, pl_byte_rdy, pl_sof, pl_eof;
  logic [7:0]  tx_byte;
  logic        tx_byte_vld, tx_byte_rdy, tx_sof, tx_eof, err_oversize;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  bit stall_en = 1'b0;
  bit gap_en = 1'b0;
  bit sof_noise = 1'b0;

  logic [7:0] pl_q[$];    // payload to send
  logic [9:0] exp_q[$];   // {sof, eof, byte}
  logic [9:0] got_q[$];

  eth_tx_framer dut (
    .sys_tx_clk  (clk),
    .sys_tx_rst  (rst),
    .dst_mac     (dst_mac),
    .ethertype   (ethertype),
    .pl_byte     (pl_byte),
    .pl_byte_vld (pl_byte_vld),
    .pl_byte_rdy (pl_byte_rdy),
    .pl_sof      (pl_sof),
    .pl_eof      (pl_eof),
    .tx_byte     (tx_byte),
    .tx_byte_vld (tx_byte_vld),
    .tx_byte_rdy (tx_byte_rdy),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, so the falling edge sees
  // exactly the values the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && tx_byte_vld && tx_byte_rdy) got_q.push_back({tx_sof, tx_eof, tx_byte});
    if (err_oversize) err_pulses++;
  end

  initial begin
    tx_byte_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_byte_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic build_exp(input logic [47:0] d, input logic [15:0] e);
    logic [111:0] hdr;
    int fwd;
    hdr = {d, MAC, e};
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back({(i == 0), 1'b0, hdr[111 - 8*i -: 8]});
    fwd = (pl_q.size() > 1500) ? 1500 : pl_q.size();
    for (int i = 0; i < fwd; i++) exp_q.push_back({2'b00, pl_q[i]});
    for (int i = fwd; i < 46; i++) exp_q.push_back(10'h000);
    exp_q[exp_q.size() - 1][8] = 1'b1;
  endtask

  task automatic rand_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [15:0] e, input int abort_at);
    bit ok;
    dst_mac   = d;
    ethertype = e;
    for (int i = 0; i < pl_q.size(); i++) begin
      if (i == abort_at) begin
        pl_byte_vld = 1'b0;
        return;
      end
      if (gap_en) begin
        pl_byte_vld = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      pl_byte     = pl_q[i];
      pl_sof      = (i == 0) || (sof_noise && ($urandom_range(0, 7) == 0));
      pl_eof      = (i == pl_q.size() - 1);
      pl_byte_vld = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 5000 && !ok; c++) begin
        @(negedge clk); ok = pl_byte_rdy;
        @(posedge clk); #1;
      end
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL handshake_timeout: byte %0d got no pl_byte_rdy, expected transfer", i);
        pl_byte_vld = 1'b0;
        return;
      end
    end
    pl_byte_vld = 1'b0;
    pl_sof = 1'b0;
    pl_eof = 1'b0;
  endtask

  // Waits only; a timeout shows up as a length difference in the caller.
  task automatic wait_frame();
    for (int c = 0; c < 5000 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pl_byte = 8'h00; pl_byte_vld = 1'b0; pl_sof = 1'b0; pl_eof = 1'b0;
    dst_mac = 48'd0; ethertype = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tx_byte_vld, tx_sof, tx_eof, err_oversize, tx_byte} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, expected 000", {tx_byte_vld, tx_sof, tx_eof, err_oversize, tx_byte});
    end
    n_cmp++;
    if (pl_byte_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pl_rdy: got %b, expected 1", pl_byte_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    err_pulses = 0;
  endtask

  task automatic test_basic();
    logic [7:0] mac_b[6];
    mac_b = '{8'h3A, 8'h52, 8'h02, 8'h3E, 8'h18, 8'h00};
    pl_q.delete();
    for (int i = 0; i < 60; i++) pl_q.push_back(8'(i));
    build_exp(48'hFFFFFFFFFFFF, 16'h0800);
    send_frame(48'hFFFFFFFFFFFF, 16'h0800, -1);
    wait_frame();
    n_cmp++;
    if (got_q.size() != 74) begin n_bad++; $display("FAIL basic_len: got %0d, expected 74", got_q.size()); end
    for (int k = 0; k < 6; k++) if (6 + k < got_q.size()) begin
      n_cmp++;
      if (got_q[6+k][7:0] !== mac_b[k]) begin
        n_bad++; $display("FAIL basic_src_mac[%0d]: got %h, expected %h", k, got_q[6+k][7:0], mac_b[k]);
      end
    end
    if (got_q.size() == 74) begin
      n_cmp++;
      if (got_q[0][9] !== 1'b1 || got_q[73][8] !== 1'b1) begin
        n_bad++; $display("FAIL basic_markers: got sof %b eof %b, expected 1 1", got_q[0][9], got_q[73][8]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
  endtask

  task automatic test_pad(input int n);
    logic [47:0] d;
    int eofs;
    d = {16'($urandom), 32'($urandom)};
    if (n == 3) pl_q = '{8'hAA, 8'hBB, 8'hCC}; else rand_payload(n);
    build_exp(d, 16'h86DD);
    send_frame(d, 16'h86DD, -1);
    wait_frame();
    n_cmp++;
    if (got_q.size() != 60) begin n_bad++; $display("FAIL pad%0d_len: got %0d, expected 60", n, got_q.size()); end
    eofs = 0;
    foreach (got_q[i]) eofs += int'(got_q[i][8]);
    n_cmp++;
    if (eofs != 1) begin n_bad++; $display("FAIL pad%0d_eof_count: got %0d, expected 1", n, eofs); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL pad%0d_byte[%0d]: got %h, expected %h", n, i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
  endtask

  task automatic test_oversize();
    logic [47:0] d;
    d = 48'h0123456789AB;
    err_pulses = 0;
    rand_payload(1600);
    build_exp(d, 16'h88B5);
    send_frame(d, 16'h88B5, -1);
    wait_frame();
    n_cmp++;
    if (got_q.size() != 1514) begin n_bad++; $display("FAIL over_len: got %0d, expected 1514", got_q.size()); end
    n_cmp++;
    if (err_pulses != 1) begin n_bad++; $display("FAIL over_err_pulse: got %0d cycles, expected 1", err_pulses); end
    if (got_q.size() >= 1514) begin
      n_cmp++;
      if (got_q[1513][8] !== 1'b1) begin n_bad++; $display("FAIL over_eof_1513: got %b, expected 1", got_q[1513][8]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL over_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    rand_payload(50);
    build_exp(d, 16'h0806);
    send_frame(d, 16'h0806, -1);
    wait_frame();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL over_next_len: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL over_next_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
  endtask

  task automatic test_stall(input int frames);
    logic [47:0] d;
    logic [15:0] e;
    stall_en = 1'b1; gap_en = 1'b1; sof_noise = (frames > 1);
    for (int f = 0; f < frames; f++) begin
      d = {16'($urandom), 32'($urandom)};
      e = 16'($urandom);
      rand_payload((frames == 1) ? 100 : $urandom_range(1, 120));
      build_exp(d, e);
      send_frame(d, e, -1);
      wait_frame();
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL stall%0d_len: got %0d, expected %0d", f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall%0d_byte[%0d]: got %h, expected %h", f, i, got_q[i], exp_q[i]); end
      end
      got_q.delete();
    end
    stall_en = 1'b0; gap_en = 1'b0; sof_noise = 1'b0;
  endtask

  task automatic test_stray_reset();
    int eofs;
    for (int k = 0; k < 5; k++) begin
      pl_byte = 8'($urandom); pl_byte_vld = 1'b1; pl_sof = 1'b0; pl_eof = 1'(k == 4);
      @(negedge clk);
      n_cmp++;
      if (tx_byte_vld !== 1'b0 || pl_byte_rdy !== 1'b1) begin
        n_bad++; $display("FAIL stray[%0d]: got vld %b rdy %b, expected 0 1", k, tx_byte_vld, pl_byte_rdy);
      end
      @(posedge clk); #1;
    end
    pl_byte_vld = 1'b0;
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL stray_forwarded: got %0d bytes, expected 0", got_q.size()); end
    rand_payload(80);
    send_frame(48'hA1A2A3A4A5A6, 16'h0800, 30);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({tx_byte_vld, tx_sof, tx_eof, err_oversize, tx_byte} !== 12'h000) begin
      n_bad++; $display("FAIL midreset_outputs: got %h, expected 000", {tx_byte_vld, tx_sof, tx_eof, err_oversize, tx_byte});
    end
    eofs = 0;
    foreach (got_q[i]) eofs += int'(got_q[i][8]);
    n_cmp++;
    if (eofs != 0 || got_q.size() != 44) begin
      n_bad++; $display("FAIL midreset_partial: got %0d bytes %0d eof, expected 44 bytes 0 eof", got_q.size(), eofs);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    got_q.delete();
    rand_payload(20);
    build_exp(48'h00005E005301, 16'h0800);
    send_frame(48'h00005E005301, 16'h0800, -1);
    wait_frame();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL postreset_len: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL postreset_byte[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad(3);
    test_pad(1);
    test_pad(45);
    test_oversize();
    test_stall(1);
    test_stall(6);
    test_stray_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
